// File: rtl/sequenciador_pilha.sv
// Stack-access sequencer: turns UC commands into push/pop strobe sequences and runs binary ops through the ULA.
// Optional DUP command is built only when SEQ_PILHA_DUP_EN is defined; otherwise cmd_op = 11 is rejected.
module sequenciador_pilha #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_func,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             pilha_push,
    output logic             pilha_pop,
    output logic             pilha_sel,
    output logic [WIDTH-1:0] pilha_din_uc,
    input  logic [WIDTH-1:0] pilha_dout,
    input  logic [15:0]      pilha_tos,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [2:0]       ula_op,
    input  logic [WIDTH-1:0] ula_result,
    output logic             done,
    output logic             erro,
    output logic [WIDTH-1:0] result
);

    localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
    localparam logic [1:0]  OP_PUSH  = 2'b00;
    localparam logic [1:0]  OP_POP   = 2'b01;
    localparam logic [1:0]  OP_BINOP = 2'b10;
`ifdef SEQ_PILHA_DUP_EN
    localparam logic [1:0]  OP_DUP   = 2'b11;
`endif

    typedef enum logic [3:0] {
        OCIOSO,
        ESCREVE,
        LE1,
        LE2,
        CAPT_A,
        CAPT,
        ULA,
`ifdef SEQ_PILHA_DUP_EN
        DUP1,
        DUP2,
`endif
        FIM,
        ERRO
    } state_t;

    state_t state_q, state_d;

    logic [1:0]       op_q, op_d;
    logic [2:0]       func_q, func_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             pilha_push_q, pilha_push_d;
    logic             pilha_pop_q, pilha_pop_d;
    logic             pilha_sel_q, pilha_sel_d;
    logic [WIDTH-1:0] pilha_din_uc_q, pilha_din_uc_d;
    logic [WIDTH-1:0] ula_a_q, ula_a_d;
    logic [WIDTH-1:0] ula_b_q, ula_b_d;
    logic [2:0]       ula_op_q, ula_op_d;
    logic             done_q, done_d;
    logic             erro_q, erro_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Next state, data captures, and registered strobes decoded from the next state
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        func_d         = func_q;
        b_d            = b_q;
        pilha_din_uc_d = pilha_din_uc_q;
        ula_a_d        = ula_a_q;
        ula_b_d        = ula_b_q;
        ula_op_d       = ula_op_q;
        result_d       = result_q;

        case (state_q)
            OCIOSO: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    func_d = cmd_func;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (pilha_tos < DEPTH_W) begin
                                state_d        = ESCREVE;
                                pilha_din_uc_d = cmd_imm;
                            end else begin
                                state_d = ERRO;
                            end
                        end
                        OP_POP:   state_d = (pilha_tos >= 16'd1) ? LE1 : ERRO;
                        OP_BINOP: state_d = (pilha_tos >= 16'd2) ? LE1 : ERRO;
`ifdef SEQ_PILHA_DUP_EN
                        default:  state_d = ((pilha_tos >= 16'd1) && (pilha_tos < DEPTH_W)) ? LE1 : ERRO;
`else
                        default:  state_d = ERRO;
`endif
                    endcase
                end
            end
            ESCREVE: state_d = FIM;
            LE1:     state_d = (op_q == OP_BINOP) ? LE2 : CAPT;
            LE2: begin
                b_d     = pilha_dout;
                state_d = CAPT_A;
            end
            CAPT_A: begin
                ula_a_d  = pilha_dout;
                ula_b_d  = b_q;
                ula_op_d = func_q;
                state_d  = ULA;
            end
            ULA: begin
                result_d = ula_result;
                state_d  = FIM;
            end
            CAPT: begin
`ifdef SEQ_PILHA_DUP_EN
                if (op_q == OP_DUP) begin
                    pilha_din_uc_d = pilha_dout;
                    state_d        = DUP1;
                end else begin
                    result_d = pilha_dout;
                    state_d  = FIM;
                end
`else
                result_d = pilha_dout;
                state_d  = FIM;
`endif
            end
`ifdef SEQ_PILHA_DUP_EN
            DUP1: state_d = DUP2;
            DUP2: state_d = FIM;
`endif
            FIM:     state_d = OCIOSO;
            ERRO:    state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase

        cmd_ready_d  = (state_d == OCIOSO);
`ifdef SEQ_PILHA_DUP_EN
        pilha_push_d = (state_d == ESCREVE) || (state_d == ULA) || (state_d == DUP1) || (state_d == DUP2);
`else
        pilha_push_d = (state_d == ESCREVE) || (state_d == ULA);
`endif
        pilha_pop_d  = (state_d == LE1) || (state_d == LE2);
        pilha_sel_d  = (state_d == ULA);
        done_d       = (state_d == FIM) || (state_d == ERRO);
        erro_d       = (state_d == ERRO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= OCIOSO;
            op_q           <= 2'b00;
            func_q         <= 3'b000;
            b_q            <= '0;
            cmd_ready_q    <= 1'b1;
            pilha_push_q   <= 1'b0;
            pilha_pop_q    <= 1'b0;
            pilha_sel_q    <= 1'b0;
            pilha_din_uc_q <= '0;
            ula_a_q        <= '0;
            ula_b_q        <= '0;
            ula_op_q       <= 3'b000;
            done_q         <= 1'b0;
            erro_q         <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            func_q         <= func_d;
            b_q            <= b_d;
            cmd_ready_q    <= cmd_ready_d;
            pilha_push_q   <= pilha_push_d;
            pilha_pop_q    <= pilha_pop_d;
            pilha_sel_q    <= pilha_sel_d;
            pilha_din_uc_q <= pilha_din_uc_d;
            ula_a_q        <= ula_a_d;
            ula_b_q        <= ula_b_d;
            ula_op_q       <= ula_op_d;
            done_q         <= done_d;
            erro_q         <= erro_d;
            result_q       <= result_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign pilha_push   = pilha_push_q;
    assign pilha_pop    = pilha_pop_q;
    assign pilha_sel    = pilha_sel_q;
    assign pilha_din_uc = pilha_din_uc_q;
    assign ula_a        = ula_a_q;
    assign ula_b        = ula_b_q;
    assign ula_op       = ula_op_q;
    assign done         = done_q;
    assign erro         = erro_q;
    assign result       = result_q;

endmodule
